// File: rtl/fetch_unit.sv
// fetch_unit: PC/instruction register with req/ack imem fetch and sequential/branch/jump next-PC.
// Optional retired-instruction counter enabled by FETCH_INSTR_CNT_EN.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  input  logic              Jump,
  input  logic              Branch,
  input  logic              Zero,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        OpCode,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              busy,
  output logic [31:0]       instr_count
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t            r_state, w_next;
  logic              r_stop_q, r_req, w_upd;
  logic [ADDR_W-1:0] r_pc, w_pc_next, w_jmp, w_br;
  logic [DATA_W-1:0] r_instr;
  assign pc_plus4  = r_pc + ADDR_W'(4);
  assign w_jmp     = {pc_plus4[ADDR_W-1:28], r_instr[25:0], 2'b00};
  assign w_br      = pc_plus4 + {{(ADDR_W-18){r_instr[15]}}, r_instr[15:0], 2'b00};
  // write-back entry: the FSM just dropped stop
  assign w_upd     = (r_state == HOLD) & r_stop_q & ~stop;
  assign w_pc_next = Jump ? w_jmp : (Branch & Zero) ? w_br : pc_plus4;
  always_comb begin
    w_next = (r_state == IDLE) ? REQ :
             (r_state == REQ)  ? (imem_ack ? HOLD : REQ) :
             (r_state == HOLD) ? (w_upd ? REQ : HOLD) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_stop_q <= 1'b0;
      r_req    <= 1'b0;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
    end else begin
      r_state  <= w_next;
      r_stop_q <= stop;
      r_req    <= (w_next == REQ);
      if (r_state == REQ && imem_ack) r_instr <= imem_rdata;
      if (w_upd) r_pc <= w_pc_next;
    end
  end
  assign imem_req  = r_req;
  assign busy      = r_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign OpCode    = r_instr[31:26];
`ifdef FETCH_INSTR_CNT_EN
  logic [31:0] r_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else if (w_upd) r_cnt <= r_cnt + 32'd1;
  end
  assign instr_count = r_cnt;
`else
  assign instr_count = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven fetch/retire vectors plus stall and mid-fetch reset sequences.
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b0;
  logic        stop = 1'b0, Jump = 1'b0, Branch = 1'b0, Zero = 1'b0;
  logic        imem_req, imem_ack = 1'b0, busy;
  logic [31:0] imem_addr, imem_rdata = '0, instr, pc, pc_plus4, instr_count;
  logic [5:0]  OpCode;
  int          n_chk = 0, n_err = 0;
  logic [31:0] exp_pc = 32'h0, exp_cnt = 32'h0;
  typedef struct {
    logic [31:0] rdata;
    logic        j, b, z;
    logic [5:0]  op;
    logic [31:0] npc;
  } vec_t;
  vec_t vt[11];
  fetch_unit dut (
    .clk(clk), .rst(rst), .stop(stop), .Jump(Jump), .Branch(Branch), .Zero(Zero),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr(instr), .OpCode(OpCode), .pc(pc), .pc_plus4(pc_plus4), .busy(busy),
    .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] cnt_exp();
`ifdef FETCH_INSTR_CNT_EN
    return exp_cnt;
`else
    return 32'h0;
`endif
  endfunction
  task automatic wait_req();
    int k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_timeout", 32'(imem_req), 32'h1);
  endtask
  task automatic fetch(input logic [31:0] d);
    chk("addr", imem_addr, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    imem_rdata = d;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("instr", instr, d);
    chk("req_hold", 32'(imem_req), 32'h0);
    chk("busy_hold", 32'(busy), 32'h0);
  endtask
  task automatic retire(input logic j, input logic b, input logic z, input logic [31:0] npc);
    logic [31:0] held;
    held = instr;
    stop = 1'b1; Jump = j; Branch = b; Zero = z;
    imem_rdata = 32'hDEAD_BEEF;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    stop = 1'b0;
    chk("pc_pre", pc, exp_pc);
    @(negedge clk);
    exp_pc = npc;
    exp_cnt++;
    chk("pc_next", pc, exp_pc);
    chk("req_again", 32'(imem_req), 32'h1);
    chk("addr_next", imem_addr, exp_pc);
    chk("instr_held", instr, held);
    chk("count", instr_count, cnt_exp());
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
  endtask
  task automatic run_vec(input int i);
    wait_req();
    fetch(vt[i].rdata);
    chk("opcode", 32'(OpCode), 32'(vt[i].op));
    retire(vt[i].j, vt[i].b, vt[i].z, vt[i].npc);
  endtask
  initial begin
    vt[0]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 6'h08, 32'h0000_0004};
    vt[1]  = '{32'h0800_0040, 1'b1, 1'b0, 1'b0, 6'h02, 32'h0000_0100};
    vt[2]  = '{32'h0800_0010, 1'b1, 1'b0, 1'b0, 6'h02, 32'h0000_0040};
    vt[3]  = '{32'h0800_0008, 1'b1, 1'b0, 1'b0, 6'h02, 32'h0000_0020};
    vt[4]  = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 6'h04, 32'h0000_001C};
    vt[5]  = '{32'h0800_0008, 1'b1, 1'b0, 1'b0, 6'h02, 32'h0000_0020};
    vt[6]  = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 6'h04, 32'h0000_0024};
    vt[7]  = '{32'h0800_0010, 1'b1, 1'b1, 1'b1, 6'h02, 32'h0000_0040};
    vt[8]  = '{32'h1000_0003, 1'b0, 1'b1, 1'b1, 6'h04, 32'h0000_0050};
    vt[9]  = '{32'h1000_FFEA, 1'b0, 1'b1, 1'b1, 6'h04, 32'hFFFF_FFFC};
    vt[10] = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 6'h08, 32'h0000_0000};
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", 32'(OpCode), 32'h0);
    chk("rst_count", instr_count, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) run_vec(i);
    chk("stall_req0", 32'(imem_req), 32'h1);
    Jump = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stop = (k == 0);
      @(negedge clk);
      chk("stall_req", 32'(imem_req), 32'h1);
      chk("stall_busy", 32'(busy), 32'h1);
      chk("stall_instr", instr, 32'h2008_0005);
      chk("stall_pc", pc, 32'h0);
    end
    Jump = 1'b0;
    stop = 1'b0;
    fetch(32'h0800_0020);
    chk("stall_pc_after", pc, 32'h0);
    retire(1'b1, 1'b0, 1'b0, 32'h0000_0080);
    chk("mid_addr", imem_addr, 32'h0000_0080);
    imem_rdata = 32'hFFFF_FFFF;
    imem_ack = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_count", instr_count, 32'h0);
    @(negedge clk);
    chk("arst_instr", instr, 32'h0);
    chk("arst_opcode", 32'(OpCode), 32'h0);
    imem_ack = 1'b0;
    rst = 1'b1;
    exp_pc = 32'h0;
    exp_cnt = 32'h0;
    for (int i = 0; i < 5; i++) run_vec(i);
`ifdef FETCH_INSTR_CNT_EN
    chk("count_five", instr_count, 32'd5);
`else
    chk("count_zero", instr_count, 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multi-cycle control FSM.
- Holds the PC and instruction register, and fetches from instruction memory over a req/ack handshake.
- Presents OpCode and the full instruction to the control FSM.
- Computes the next PC (sequential, branch, jump) from the FSM's stop, Jump and Branch outputs and the ALU Zero flag.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width
- DATA_W, 32, instruction width (fixed MIPS format, must be 32)
- RESET_PC, 32'h0000_0000, PC value after reset

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- stop  input  1  from control FSM; high while an instruction is in decode/exe
- Jump  input  1  from control FSM; unconditional jump
- Branch  input  1  from control FSM; conditional branch (beq)
- Zero  input  1  ALU zero flag; valid while Branch is high
- imem_req  output  1  instruction-memory read request
- imem_addr  output  ADDR_W  read address (equals pc)
- imem_rdata  input  DATA_W  read data; valid when imem_ack=1
- imem_ack  input  1  read-data valid strobe
- instr  output  DATA_W  instruction register
- OpCode  output  6  instr[31:26], to control FSM
- pc  output  ADDR_W  address of the current instruction
- pc_plus4  output  ADDR_W  pc+4, combinational
- busy  output  1  fetch outstanding (REQ state)
- instr_count  output  32  retired-instruction counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_PC, instr=0 (so OpCode=0), imem_req=0, busy=0, stop_q=0, instr_count=0.
  - Reset mid-fetch aborts the request; any late ack is ignored.
- stop_q: registers stop each cycle. Update event = stop_q & ~stop, i.e. the FSM entering write-back.
- State IDLE: next cycle goes to REQ and drives imem_req=1, imem_addr=pc.
- State REQ:
  - imem_req=1, busy=1.
  - On imem_ack=1: instr<=imem_rdata, go to HOLD, imem_req=0 the following cycle.
  - Single-cycle memory: ack in the first REQ cycle gives 1-cycle fetch latency. Integration requires this so that OpCode is stable before FSM decode.
- State HOLD:
  - instr and OpCode are held stable; imem_req=0.
  - Waits for the update event, then performs the PC update below and goes to REQ in the next cycle.
- PC update, one cycle, priority order:
  - Jump=1: pc <= {pc_plus4[31:28], instr[25:0], 2'b00}
  - Branch=1 and Zero=1: pc <= pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})
  - otherwise: pc <= pc_plus4
  - Jump and Branch both high: Jump wins.
  - Branch=1 with Zero=0: sequential.
- Arithmetic:
  - Modulo 2^ADDR_W; wrap 32'hFFFF_FFFC -> 32'h0000_0000 without flagging.
  - pc[1:0] is always 0.
- Ignored events:
  - imem_ack outside REQ.
  - Update event outside HOLD (the fetch has not completed, so the event is dropped).
  - stop toggling while in REQ has no effect on pc.
- Outputs are registered except pc_plus4 and OpCode (a slice of instr).

Optional Feature:
- Macro: FETCH_INSTR_CNT_EN
- Defined:
  - instr_count is a 32-bit register, reset to 0.
  - Increments by 1 on every PC update event taken in HOLD.
  - Wraps from 32'hFFFF_FFFF to 0.
- Undefined: instr_count tied to 32'h0; no counter flop is instantiated.

Test Plan:
- Reset release with RESET_PC=0, imem_ack same cycle as req, imem_rdata=32'h2008_0005 (addi) -> instr=32'h2008_0005, OpCode=6'h08, pc=0. After a stop pulse 1->0 with Jump=Branch=0: pc=4, new imem_req with addr=4.
- instr=32'h0800_0010 (j), Jump=1 at stop fall, pc=32'h0000_0100 -> pc=32'h0000_0040.
- instr=32'h1000_FFFE (beq, offset -2), Branch=1, Zero=1, pc=32'h0000_0020 -> pc=32'h0000_001C. Repeat with Zero=0 -> pc=32'h0000_0024.
- Memory stalls ack for 3 cycles -> imem_req and busy held high for 3 cycles; instr unchanged until ack; a stop fall during the stall is ignored and pc is unchanged.
- Assert rst=0 mid-REQ at pc=32'h0000_0080 -> imem_req=0, pc=RESET_PC asynchronously; an ack arriving during reset does not load instr.
- With FETCH_INSTR_CNT_EN: 5 completed instructions -> instr_count=5. Without the macro: instr_count=0 throughout.
